// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - PAUSE_* : hazard codes driven by the register file; any nonzero code stalls fetch
//   - fetch_state_e : front-end FSM encoding
//   - NOP_INSTR_DEFAULT : word loaded into IF/ID on reset/flush (sll $0,$0,0)
package fetch_stage_pkg;

    localparam logic [1:0] PAUSE_NO   = 2'b00;
    localparam logic [1:0] PAUSE_RS   = 2'b01;
    localparam logic [1:0] PAUSE_RT   = 2'b10;
    localparam logic [1:0] PAUSE_BOTH = 2'b11;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        StBoot  = 2'b00,
        StRun   = 2'b01,
        StStall = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   hold                : keep current contents (stall / boot)
//   flush               : replace contents with NOP, valid cleared
//   load_instr/load_pc4 : fetched word and its PC+4, captured when not held
//   instr, pc4, valid   : registered outputs towards decode
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc4,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    // Hold wins over flush: a stalled front end must not lose the word decode is waiting on.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (hold) begin
            instr_q <= instr_q;
            pc4_q   <= pc4_q;
            valid_q <= valid_q;
        end else if (flush) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= load_instr;
            pc4_q   <= load_pc4;
            valid_q <= 1'b1;
        end
    end

    assign instr = instr_q;
    assign pc4   = pc4_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, front-end FSM (BOOT/RUN/STALL), stall counter and IF/ID register.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   pause                        : register-file hazard code; nonzero freezes the front end
//   branch_taken, branch_target  : redirect resolved in decode (low two target bits ignored)
//   imem_addr, imem_rdata        : asynchronous instruction memory (address = PC)
//   if_id_instr/pc4/valid        : IF/ID contents for decode
//   id_bubble                    : decode must suppress register write this cycle
//   stall_cycles                 : saturating count of stalled cycles since reset
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pause,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        id_bubble,
    output logic [15:0] stall_cycles
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [15:0]  stall_cnt_q, stall_cnt_d;
    logic [31:0]  pc_plus4;
    logic         stall;
    logic         ifid_hold;
    logic         ifid_flush;

    assign stall    = (pause != PAUSE_NO);
    assign pc_plus4 = pc_q + 32'd4;

    // RUN and STALL share the update rule: leaving STALL performs the normal RUN update in the
    // same cycle, and while stalled the branch request is ignored because its operands are stale.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_hold  = 1'b1;
        ifid_flush = 1'b0;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun, StStall: begin
                if (stall) begin
                    state_d = StStall;
                end else begin
                    state_d   = StRun;
                    ifid_hold = 1'b0;
                    if (branch_taken) begin
                        pc_d       = branch_target & ~32'h3;
                        ifid_flush = 1'b1;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q != StBoot && stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StBoot;
            pc_q        <= RESET_PC;
            stall_cnt_q <= 16'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .hold       (ifid_hold),
        .flush      (ifid_flush),
        .load_instr (imem_rdata),
        .load_pc4   (pc_plus4),
        .instr      (if_id_instr),
        .pc4        (if_id_pc4),
        .valid      (if_id_valid)
    );

    assign imem_addr    = pc_q;
    assign stall_cycles = stall_cnt_q;
    // Outside RUN the bubble is forced anyway; in RUN a live stall or an empty slot also forces it.
    assign id_bubble    = (state_q != StRun) || stall || !if_id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] TAG = 32'hDEAD_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pause = 2'b00;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        id_bubble;
    logic [15:0] stall_cycles;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    // Address-tagged instruction memory.
    assign imem_rdata = imem_addr ^ TAG;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pause         (pause),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .id_bubble     (id_bubble),
        .stall_cycles  (stall_cycles)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        chk_pc4;
        logic        valid;
        logic        bubble;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model of the front end, in spec terms.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_pc4 = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_boot = 1'b1;
    logic        m_stalled = 1'b0;
    logic [15:0] m_cnt = 16'h0;
    logic        m_pc4_known = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_asserts++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic step(input logic [1:0] p, input logic bt, input logic [31:0] tgt,
                        input logic r);
        exp_t e;
        exp_t g;
        logic s;
        @(negedge clk);
        pause = p;
        branch_taken = bt;
        branch_target = tgt;
        rst = r;
        s = (p != 2'b00);
        if (r) begin
            m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
            m_boot = 1'b1; m_stalled = 1'b0; m_cnt = 16'h0; m_pc4_known = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (s) begin
            m_stalled = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
            m_stalled = 1'b0;
            if (bt) begin
                m_pc = tgt & 32'hFFFF_FFFC;
                m_instr = NOP; m_valid = 1'b0; m_pc4_known = 1'b0;
            end else begin
                m_instr = m_pc ^ TAG;
                m_pc4 = m_pc + 32'd4;
                m_valid = 1'b1; m_pc4_known = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.chk_pc4 = m_pc4_known;
        e.valid = m_valid; e.cnt = m_cnt;
        e.bubble = m_boot || m_stalled || s || !m_valid;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        n_asserts++;
        assert (exp_q.size() != 0)
        else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end
        if (exp_q.size() != 0) begin
            g = exp_q.pop_front();
            chk("imem_addr", imem_addr, g.pc);
            chk("if_id_instr", if_id_instr, g.instr);
            if (g.chk_pc4) chk("if_id_pc4", if_id_pc4, g.pc4);
            chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, g.valid});
            chk("id_bubble", {31'h0, id_bubble}, {31'h0, g.bubble});
            chk("stall_cycles", {16'h0, stall_cycles}, {16'h0, g.cnt});
        end
    endtask

    initial begin
        // Reset, then check the reset state against fixed values too.
        step(2'b00, 1'b0, 32'h0, 1'b1);
        step(2'b00, 1'b0, 32'h0, 1'b1);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_pc4", if_id_pc4, 32'h0);
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_bubble", {31'h0, id_bubble}, 32'h1);
        chk("rst_cnt", {16'h0, stall_cycles}, 32'h0);

        // Free run: boot cycle, then fetch 0,4,8,C reaching PC=0x10.
        step(2'b00, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(2'b00, 1'b0, 32'h0, 1'b0);
        chk("run_pc_0x10", imem_addr, 32'h10);
        chk("run_pc4_0x10", if_id_pc4, 32'h10);

        // Three-cycle RS stall at PC=0x10, then resume.
        for (int i = 0; i < 3; i++) step(2'b01, 1'b0, 32'h0, 1'b0);
        chk("stall_cnt_3", {16'h0, stall_cycles}, 32'd3);
        chk("stall_pc_held", imem_addr, 32'h10);
        step(2'b00, 1'b0, 32'h0, 1'b0);
        chk("resume_pc", imem_addr, 32'h14);
        chk("resume_instr", if_id_instr, 32'h10 ^ TAG);

        // Advance to 0x20, redirect to 0x100.
        for (int i = 0; i < 3; i++) step(2'b00, 1'b0, 32'h0, 1'b0);
        step(2'b00, 1'b1, 32'h100, 1'b0);
        chk("br_pc", imem_addr, 32'h100);
        chk("br_flush_valid", {31'h0, if_id_valid}, 32'h0);
        step(2'b00, 1'b0, 32'h0, 1'b0);
        chk("br_target_instr", if_id_instr, 32'h100 ^ TAG);
        chk("br_target_pc4", if_id_pc4, 32'h104);

        // Branch under BOTH stall is ignored; taken once reasserted without stall.
        step(2'b11, 1'b1, 32'h200, 1'b0);
        chk("br_stall_no_redirect", imem_addr, 32'h104);
        step(2'b00, 1'b1, 32'h200, 1'b0);
        chk("br_after_stall", imem_addr, 32'h200);

        // Reset in the middle of a stall with the counter at 5.
        step(2'b10, 1'b0, 32'h0, 1'b0);
        chk("cnt_5", {16'h0, stall_cycles}, 32'd5);
        step(2'b10, 1'b1, 32'h300, 1'b1);
        chk("mid_rst_pc", imem_addr, 32'h0);
        chk("mid_rst_cnt", {16'h0, stall_cycles}, 32'h0);
        step(2'b00, 1'b0, 32'h0, 1'b0);
        step(2'b00, 1'b0, 32'h0, 1'b0);
        chk("post_rst_pc", imem_addr, 32'h4);

        // Redirect to the top word (low bits forced), then wrap.
        step(2'b00, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("top_pc", imem_addr, 32'hFFFF_FFFC);
        step(2'b00, 1'b0, 32'h0, 1'b0);
        chk("wrap_pc", imem_addr, 32'h0);
        chk("wrap_pc4", if_id_pc4, 32'h0);
        chk("wrap_instr", if_id_instr, 32'hFFFF_FFFC ^ TAG);
        step(2'b00, 1'b0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
